// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (alu_seq) and its iterative
// multiply/divide engine (alu_seq_iter):
//   - 4-bit opcode constants
//   - FSM state enum
//   - registered flag bundle
// The divider opcodes (OP_DIV, OP_REM) are only executed when the design is
// built with ALU_SEQ_DIV_EN defined; otherwise they complete as illegal ops.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NEG = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_REM = 4'b1011;
    localparam logic [3:0] OP_SRA = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/alu_seq_iter.sv
// ---------------------------------------------------------------------------
// alu_seq_iter
// Iterative engine shared by multiply and (optionally) divide. Operands are
// latched as magnitudes on 'start'; the engine then runs exactly WIDTH
// iterations, one per clock, and the signed results are formed from the
// final magnitudes combinationally.
//   multiply : shift-add, {hi,lo} ends as the 2*WIDTH-bit magnitude product
//   divide   : restoring, lo ends as quotient, hi as remainder
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               load operands and begin WIDTH iterations
//   div_mode            1 = divide, 0 = multiply (ALU_SEQ_DIV_EN only)
//   a, b                signed operands, sampled on start
//   done                high when no iterations are pending
//   mul_prod            signed 2*WIDTH-bit product
//   div_quot, div_rem   signed quotient / remainder (ALU_SEQ_DIV_EN only)
//
// Build option: ALU_SEQ_DIV_EN compiles in the divide datapath.
// ---------------------------------------------------------------------------
module alu_seq_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] mul_prod
`ifdef ALU_SEQ_DIV_EN
    ,
    input  logic               div_mode,
    output logic [WIDTH-1:0]   div_quot,
    output logic [WIDTH-1:0]   div_rem
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
    logic             mode_q, mode_d;
    logic             a_neg_q, a_neg_d;
    logic [WIDTH-1:0] div_shift;
    logic [WIDTH:0]   div_diff;
`endif

    // Magnitudes fit in WIDTH unsigned bits, including |most negative|.
    always_comb begin
        mag_a = a[WIDTH-1] ? ('0 - a) : a;
        mag_b = b[WIDTH-1] ? ('0 - b) : b;
    end

    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
`ifdef ALU_SEQ_DIV_EN
        mode_d  = mode_q;
        a_neg_d = a_neg_q;
        // Partial remainder shifted left with the next dividend bit; the
        // extra top bit of the difference is the "went negative" indicator.
        div_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, mcand_q};
`endif
        // Add the multiplicand when the current multiplier LSB is set, then
        // the whole {hi,lo} pair shifts right by one.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

        if (start) begin
            cnt_d   = CW'(WIDTH);
            hi_d    = '0;
            lo_d    = mag_a;
            mcand_d = mag_b;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_SEQ_DIV_EN
            mode_d  = div_mode;
            a_neg_d = a[WIDTH-1];
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
`ifdef ALU_SEQ_DIV_EN
            if (mode_q) begin
                if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift;
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            mode_q  <= 1'b0;
            a_neg_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
`ifdef ALU_SEQ_DIV_EN
            mode_q  <= mode_d;
            a_neg_q <= a_neg_d;
`endif
        end
    end

    assign done     = (cnt_q == '0);
    assign mul_prod = neg_q ? ('0 - {hi_q, lo_q}) : {hi_q, lo_q};
`ifdef ALU_SEQ_DIV_EN
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign div_quot = neg_q ? ('0 - lo_q) : lo_q;
    assign div_rem  = a_neg_q ? ('0 - hi_q) : hi_q;
`endif

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential signed ALU with valid/ready handshakes on both sides. One
// operation is in flight at a time: accept in IDLE, compute (1 cycle, or
// WIDTH iterations in MUL/DIV), present result and flags in DONE until the
// consumer takes them.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = idle)
//   op, a, b              opcode and signed operands, sampled on accept
//   out_valid / out_ready result handshake
//   result                result (low product half for MUL)
//   result_hi             high product half (MUL), remainder (DIV), else 0
//   zero, carry, overflow, negative, illegal   flags registered with result
//
// Build option: ALU_SEQ_DIV_EN enables DIV/REM (1010/1011); without it those
// opcodes complete in one cycle flagged illegal.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);

    localparam int               SHW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   WIDTH_EXT = (WIDTH+1)'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    flags_t           flags_q, flags_d;
    logic             load;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [WIDTH-1:0] neg_res;
    logic [SHW-1:0]   shamt;
    logic             shift_big;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_illegal;

    logic               iter_start;
    logic               iter_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_ovf;
`ifdef ALU_SEQ_DIV_EN
    logic               iter_div;
    logic [WIDTH-1:0]   div_quot;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [3:0]         op_q, op_d;
    logic               b_zero_q, b_zero_d;
`endif

    alu_seq_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (iter_start),
        .a        (a),
        .b        (b),
        .done     (iter_done),
        .mul_prod (mul_prod)
`ifdef ALU_SEQ_DIV_EN
        ,
        .div_mode (iter_div),
        .div_quot (div_quot),
        .div_rem  (div_rem)
`endif
    );

    // Product fits in WIDTH bits only if the top WIDTH+1 bits are all sign.
    assign mul_ovf = ~(&mul_prod[2*WIDTH-1:WIDTH-1]) & (|mul_prod[2*WIDTH-1:WIDTH-1]);

    // Single-cycle datapath, evaluated straight from the live inputs so the
    // result can be registered on the accept edge.
    always_comb begin
        add_sum    = {1'b0, a} + {1'b0, b};
        sub_diff   = a - b;
        neg_res    = '0 - b;
        shamt      = b[SHW-1:0];
        shift_big  = ({1'b0, b} >= WIDTH_EXT);
        sc_result  = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = add_sum[WIDTH-1:0];
                sc_carry  = add_sum[WIDTH];
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = sub_diff;
                sc_carry  = (a < b);
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NEG: begin
                sc_result = neg_res;
                sc_ovf    = (b == MOST_NEG);
            end
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_NOT: sc_result = ~a;
            OP_XOR: sc_result = a ^ b;
            OP_SLL: sc_result = shift_big ? '0 : (a << shamt);
            OP_SRL: sc_result = shift_big ? '0 : (a >> shamt);
            OP_SRA: sc_result = shift_big ? {WIDTH{a[WIDTH-1]}}
                                          : WIDTH'($signed(a) >>> shamt);
            default: sc_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        iter_start  = 1'b0;
        load        = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        iter_div    = 1'b0;
        a_d         = a_q;
        op_d        = op_q;
        b_zero_d    = b_zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        iter_start = 1'b1;
                        state_d    = ST_MUL;
                    end
`ifdef ALU_SEQ_DIV_EN
                    else if (op == OP_DIV || op == OP_REM) begin
                        iter_start = 1'b1;
                        iter_div   = 1'b1;
                        a_d        = a;
                        op_d       = op;
                        b_zero_d   = (b == '0);
                        state_d    = ST_DIV;
                    end
`endif
                    else begin
                        result_d         = sc_result;
                        result_hi_d      = '0;
                        flags_d.carry    = sc_carry;
                        flags_d.overflow = sc_ovf;
                        flags_d.illegal  = sc_illegal;
                        load             = 1'b1;
                        state_d          = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (iter_done) begin
                    result_d         = mul_prod[WIDTH-1:0];
                    result_hi_d      = mul_prod[2*WIDTH-1:WIDTH];
                    flags_d.carry    = 1'b0;
                    flags_d.overflow = mul_ovf;
                    flags_d.illegal  = 1'b0;
                    load             = 1'b1;
                    state_d          = ST_DONE;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                if (iter_done) begin
                    flags_d.carry    = 1'b0;
                    flags_d.overflow = 1'b0;
                    flags_d.illegal  = 1'b0;
                    // Divide by zero still spends the full iteration count so
                    // latency never depends on operand values.
                    if (b_zero_q) begin
                        result_d         = '1;
                        result_hi_d      = a_q;
                        flags_d.overflow = 1'b1;
                    end else if (op_q == OP_DIV) begin
                        result_d    = div_quot;
                        result_hi_d = div_rem;
                    end else begin
                        result_d    = div_rem;
                        result_hi_d = '0;
                    end
                    load    = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // zero/negative follow the newly loaded result only; between loads
        // the flags hold, so the post-reset all-zero state is preserved.
        if (load) begin
            flags_d.zero     = (result_d == '0);
            flags_d.negative = result_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
`ifdef ALU_SEQ_DIV_EN
            a_q         <= '0;
            op_q        <= '0;
            b_zero_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
`ifdef ALU_SEQ_DIV_EN
            a_q         <= a_d;
            op_q        <= op_d;
            b_zero_q    <= b_zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;
    assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq at WIDTH = 8. A table of hand-computed vectors
// covers every opcode class and the shift / overflow boundaries; extra
// sequences cover back-pressure in DONE and reset in the middle of a MUL.
// Flag vectors are packed as {zero, carry, overflow, negative, illegal}.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         negative;
    logic         illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] flg;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic [3:0] o,
                                input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] r, input logic [7:0] h,
                                input logic [4:0] f, input int l);
        vec_t v;
        v.nm = nm; v.op = o; v.a = x; v.b = y;
        v.res = r; v.hi = h; v.flg = f; v.lat = l;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Present one operation and let it be accepted on the next rising edge;
    // the operand bus is scrambled afterwards since it is don't-care.
    task automatic applyStimulus(input string nm, input logic [3:0] o,
                                 input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        check({nm, "_in_ready"}, 16'(in_ready), 16'd1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic checkOutput(input string nm, input logic [7:0] er,
                               input logic [7:0] eh, input logic [4:0] ef,
                               input int el, input int hold);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check({nm, "_latency"}, 16'(lat), 16'(el));
        check({nm, "_result"}, 16'(result), 16'(er));
        check({nm, "_result_hi"}, 16'(result_hi), 16'(eh));
        check({nm, "_flags"}, 16'({zero, carry, overflow, negative, illegal}), 16'(ef));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({nm, "_hold_valid"}, 16'(out_valid), 16'd1);
            check({nm, "_hold_in_ready"}, 16'(in_ready), 16'd0);
            check({nm, "_hold_result"}, 16'({result_hi, result}), {eh, er});
            check({nm, "_hold_flags"}, 16'({zero, carry, overflow, negative, illegal}), 16'(ef));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({nm, "_release_valid"}, 16'(out_valid), 16'd0);
        check({nm, "_release_in_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;

        vecs.push_back(mk("add_ovf",   OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b00110, 1));
        vecs.push_back(mk("add_carry", OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b11000, 1));
        vecs.push_back(mk("sub_borrow",OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h00, 5'b01010, 1));
        vecs.push_back(mk("sub_ovf",   OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("neg_min",   OP_NEG, 8'h33, 8'h80, 8'h80, 8'h00, 5'b00110, 1));
        vecs.push_back(mk("neg_5",     OP_NEG, 8'h00, 8'h05, 8'hFB, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("and",       OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1));
        vecs.push_back(mk("or",        OP_OR,  8'h0F, 8'h30, 8'h3F, 8'h00, 5'b00000, 1));
        vecs.push_back(mk("not",       OP_NOT, 8'h0F, 8'h55, 8'hF0, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("xor_zero",  OP_XOR, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b10000, 1));
        vecs.push_back(mk("sll_1",     OP_SLL, 8'h81, 8'h01, 8'h02, 8'h00, 5'b00000, 1));
        vecs.push_back(mk("sll_big",   OP_SLL, 8'h01, 8'h08, 8'h00, 8'h00, 5'b10000, 1));
        vecs.push_back(mk("srl_3",     OP_SRL, 8'h80, 8'h03, 8'h10, 8'h00, 5'b00000, 1));
        vecs.push_back(mk("sra_3",     OP_SRA, 8'h80, 8'h03, 8'hF0, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("sra_big",   OP_SRA, 8'h90, 8'h20, 8'hFF, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("srl_big",   OP_SRL, 8'hF0, 8'h09, 8'h00, 8'h00, 5'b10000, 1));
        vecs.push_back(mk("mul_m3x50", OP_MUL, 8'hFD, 8'h32, 8'h6A, 8'hFF, 5'b00100, 9));
        vecs.push_back(mk("mul_5x6",   OP_MUL, 8'h05, 8'h06, 8'h1E, 8'h00, 5'b00000, 9));
        vecs.push_back(mk("mul_minsq", OP_MUL, 8'h80, 8'h80, 8'h00, 8'h40, 5'b10100, 9));
        vecs.push_back(mk("mul_m1x7",  OP_MUL, 8'hFF, 8'h07, 8'hF9, 8'hFF, 5'b00010, 9));
        vecs.push_back(mk("illegal_d", 4'hD,   8'h12, 8'h34, 8'h00, 8'h00, 5'b10001, 1));
        vecs.push_back(mk("illegal_f", 4'hF,   8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10001, 1));
`ifdef ALU_SEQ_DIV_EN
        vecs.push_back(mk("div_m7_2",  OP_DIV, 8'hF9, 8'h02, 8'hFD, 8'hFF, 5'b00010, 9));
        vecs.push_back(mk("rem_7_m2",  OP_REM, 8'h07, 8'hFE, 8'h01, 8'h00, 5'b00000, 9));
        vecs.push_back(mk("div_zero",  OP_DIV, 8'h25, 8'h00, 8'hFF, 8'h25, 5'b00110, 9));
`else
        vecs.push_back(mk("div_absent",OP_DIV, 8'hF9, 8'h02, 8'h00, 8'h00, 5'b10001, 1));
        vecs.push_back(mk("rem_absent",OP_REM, 8'h07, 8'hFE, 8'h00, 8'h00, 5'b10001, 1));
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 16'(in_ready), 16'd1);
        check("reset_out_valid", 16'(out_valid), 16'd0);
        check("reset_result", 16'({result_hi, result}), 16'h0000);
        check("reset_flags", 16'({zero, carry, overflow, negative, illegal}), 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_flags", 16'({zero, carry, overflow, negative, illegal}), 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput(vecs[i].nm, vecs[i].res, vecs[i].hi, vecs[i].flg, vecs[i].lat, 0);
        end

        // Consumer stalls for 5 cycles while the result sits in DONE.
        applyStimulus("backpressure", OP_ADD, 8'h10, 8'h20);
        checkOutput("backpressure", 8'h30, 8'h00, 5'b00000, 1, 5);

        // Reset during the fourth cycle of a multiply abandons it.
        applyStimulus("rst_mul", OP_MUL, 8'h03, 8'h04);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mul_in_ready", 16'(in_ready), 16'd1);
        check("rst_mul_out_valid", 16'(out_valid), 16'd0);
        check("rst_mul_result", 16'({result_hi, result}), 16'h0000);
        check("rst_mul_flags", 16'({zero, carry, overflow, negative, illegal}), 16'h0000);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("rst_mul_no_valid", 16'(seen), 16'd0);
        applyStimulus("post_rst_add", OP_ADD, 8'h02, 8'h03);
        checkOutput("post_rst_add", 8'h05, 8'h00, 5'b00000, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised ALU that extends the team's combinational 4-bit ALU. It has a valid/ready operand and result handshake, a registered result and flags, and an iterative multiplier. The optional divider is iterative too. It sits between the operand/control register stage and the display/writeback stage, and accepts one operation at a time.

## Interface
- `WIDTH`, 8: operand and result width in bits, two's complement, ≥ 4.
- `SHW`, `$clog2(WIDTH)`: shift-amount field width (derived localparam).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand/opcode presented.
- `in_ready` output 1: block idle, can accept.
- `op` input 4: opcode.
- `a`, `b` input WIDTH: signed operands.
- `out_valid` output 1: result/flags valid.
- `out_ready` input 1: consumer takes result.
- `result` output WIDTH: result (low half for multiply).
- `result_hi` output WIDTH: upper product half for MUL, remainder for DIV, else 0.
- `zero`, `carry`, `overflow`, `negative`, `illegal` output 1 each: flags registered with `result`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. `in_ready` = (state == IDLE).
- Transfers happen when `in_valid & in_ready` (input side) or `out_valid & out_ready` (output side). Operands and op are latched on accept.
- Single-cycle opcodes, IDLE→DONE:
  - 0000 ADD
  - 0001 SUB
  - 0010 NEG b
  - 0100 AND, 0101 OR, 0110 NOT a, 0111 XOR
  - 1000 SLL, 1001 SRL (logical), 1100 SRA
- Shifts use `b[SHW-1:0]`. If `b` is ≥ WIDTH as unsigned, SLL/SRL give 0 and SRA gives sign fill.
- 0011 MUL: IDLE→MUL. Signed shift-add over magnitudes, one bit per cycle for WIDTH cycles, sign fixed at the end, then →DONE. `{result_hi,result}` holds the full 2·WIDTH product.
- 1010 DIV / 1011 REM: only with the divider compiled in (see Configuration). IDLE→DIV, restoring, WIDTH cycles, then →DONE. Quotient is truncated toward zero and the remainder takes the sign of `a`.
- Divide by zero: `result` = all ones, `result_hi` = `a`, `overflow` = 1, still WIDTH cycles.
- Opcodes 1101–1111, and 1010/1011 when the divider is absent: →DONE, `result` = 0, `illegal` = 1.
- DONE holds all outputs stable until `out_ready`, then →IDLE. No new accept happens in the same cycle.
- Flag rules:
  - `zero` = (`result` == 0); `negative` = `result[WIDTH-1]`.
  - ADD: `carry` = unsigned carry-out; `overflow` = same-sign operands with a different-sign result.
  - SUB: `carry` = borrow (`a` < `b` unsigned); `overflow` = operands of different sign and result sign ≠ `a` sign.
  - NEG: `overflow` = (`b` == most negative).
  - MUL: `overflow` = product not representable in WIDTH bits; `carry` = 0.
  - All other operations: `carry` = `overflow` = 0.
- Flags are computed from the final result, never from the previous one.

## Timing
- Reset value: state IDLE, `in_ready` = 1, `out_valid` = 0, `result` = `result_hi` = 0, all flags 0.
- Latency from accept edge to `out_valid` high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
- Throughput: one operation per (latency + 1) cycles when `out_ready` is held high.
- Reset asserted mid-MUL/DIV or in DONE aborts the operation. State returns to IDLE immediately and the pending result is discarded.
- Inputs `a`, `b`, `op` are don't-care after accept.

## Configuration
- `ALU_SEQ_DIV_EN` defined: the DIV state and divider datapath are compiled in, and 1010/1011 are legal.
- `ALU_SEQ_DIV_EN` undefined: no divider logic; 1010/1011 complete in 1 cycle with `illegal` = 1 and `result` = 0.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants: `OP_ADD` … `OP_SRA`, `OP_DIV`, `OP_REM`.
  - FSM state enum.
  - The flag bundle struct.
- One sub-module, `alu_seq_iter`: a shared iterative shift-add / restoring-subtract engine with a WIDTH-cycle counter. The top module keeps the FSM, single-cycle datapath and flag logic.

## Test plan
All scenarios use WIDTH = 8.
- ADD 0x7F + 0x01 → `result` 0x80, `overflow` = 1, `carry` = 0, `negative` = 1, `out_valid` 1 cycle after accept.
- SUB 0x00 − 0x01 → 0xFF, `carry` = 1, `overflow` = 0. NEG 0x80 → 0x80, `overflow` = 1.
- MUL −3 × 50 → {`result_hi`,`result`} = 0xFF6A (−150), `overflow` = 1, `out_valid` exactly 9 cycles after accept.
- Back-pressure: hold `out_ready` = 0 for 5 cycles after `out_valid` → outputs stable, `in_ready` = 0; release → IDLE next cycle.
- `rst` pulse at cycle 4 of a MUL → `out_valid` never rises, `in_ready` = 1 after reset, the next ADD behaves normally.
- With `ALU_SEQ_DIV_EN`: DIV −7 / 2 → `result` −3, `result_hi` −1; DIV by 0 → `result` 0xFF, `overflow` = 1. Without the macro: op 1010 → `illegal` = 1, `result` 0.
